pdp_mem_arbiter: RTL and testbench

Single-port memory arbiter placed between the PDP-8 front end (`instr_decode` fetch port) and execution unit (`instr_exec` read/write ports) on one side and a single-port, one-cycle-latency memory on the other. Grants at most one access per cycle and returns each response exactly one cycle after issue. Priority is fixed, with a starvation guard so instruction fetch always makes progress.

---
 rtl/pdp8_pkg.sv | 11 +
 rtl/pdp_mem_arbiter.sv | 83 ++++++++
 tb/tb_pdp_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - shared PDP-8 widths and memory-arbiter owner encoding
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;
    typedef enum logic [1:0] {GNT_NONE, GNT_IFU, GNT_EXEC_RD, GNT_EXEC_WR} pdp_mem_owner_e;
endpackage

// File: rtl/pdp_mem_arbiter.sv
// rtl/pdp_mem_arbiter.sv - single-port memory arbiter for fetch, operand read and write
module pdp_mem_arbiter
    import pdp8_pkg::*;
#(
    parameter int ADDR_WIDTH   = `ADDR_WIDTH,
    parameter int DATA_WIDTH   = `DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_rd_valid,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  exec_wr_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    pdp_mem_owner_e owner_q, owner_d;
    logic [CW-1:0]  starve_cnt_q, starve_cnt_d;
    logic           ifu_elig, rd_elig, wr_elig;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q      <= GNT_NONE;
            starve_cnt_q <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Gating with reset_n keeps the combinational memory port quiet while reset is held.
    always_comb begin
        ifu_elig = reset_n && ifu_rd_req  && (owner_q != GNT_IFU);
        rd_elig  = reset_n && exec_rd_req && (owner_q != GNT_EXEC_RD);
        wr_elig  = reset_n && exec_wr_req && (owner_q != GNT_EXEC_WR);

        owner_d = GNT_NONE;
        if (ifu_elig && (starve_cnt_q == LIMIT)) owner_d = GNT_IFU;
        else if (wr_elig)                        owner_d = GNT_EXEC_WR;
        else if (rd_elig)                        owner_d = GNT_EXEC_RD;
        else if (ifu_elig)                       owner_d = GNT_IFU;

        starve_cnt_d = starve_cnt_q;
        if (owner_d == GNT_IFU)                     starve_cnt_d = '0;
        else if (ifu_elig && (starve_cnt_q != LIMIT)) starve_cnt_d = starve_cnt_q + CW'(1);
    end

    always_comb begin
        mem_req   = (owner_d != GNT_NONE);
        mem_we    = (owner_d == GNT_EXEC_WR);
        mem_addr  = '0;
        mem_wdata = '0;
        case (owner_d)
            GNT_IFU:     mem_addr = ifu_rd_addr;
            GNT_EXEC_RD: mem_addr = exec_rd_addr;
            GNT_EXEC_WR: begin
                mem_addr  = exec_wr_addr;
                mem_wdata = exec_wr_data;
            end
            default: ;
        endcase
        ifu_rd_valid  = (owner_q == GNT_IFU);
        exec_rd_valid = (owner_q == GNT_EXEC_RD);
        exec_wr_done  = (owner_q == GNT_EXEC_WR);
        ifu_rd_data   = mem_rdata;
        exec_rd_data  = mem_rdata;
    end
endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// tb/tb_pdp_mem_arbiter.sv - self-checking bench for pdp_mem_arbiter against a memory/priority model
module tb_pdp_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 12;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ifu_rd_req, exec_rd_req, exec_wr_req;
    logic [AW-1:0] ifu_rd_addr, exec_rd_addr, exec_wr_addr;
    logic [DW-1:0] exec_wr_data, mem_rdata;
    logic [DW-1:0] ifu_rd_data, exec_rd_data, mem_wdata;
    logic          ifu_rd_valid, exec_rd_valid, exec_wr_done;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;

    pdp_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
        .ifu_rd_data(ifu_rd_data), .ifu_rd_valid(ifu_rd_valid),
        .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
        .exec_rd_data(exec_rd_data), .exec_rd_valid(exec_rd_valid),
        .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr),
        .exec_wr_data(exec_wr_data), .exec_wr_done(exec_wr_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: 0 none, 1 fetch, 2 exec read, 3 exec write
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    int            m_owner, m_wait, last_pulse;
    logic [DW-1:0] m_rd_val;
    int            s_g;
    logic          s_mem_req, s_mem_we, s_ifu_valid, s_rd_valid, s_wr_done;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_mem_wdata, s_ifu_data, s_rd_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit e_ifu, e_rd, e_wr;
        int g;
        logic [AW-1:0] ea;
        @(negedge clk);
        e_ifu = ifu_rd_req  && m_owner != 1;
        e_rd  = exec_rd_req && m_owner != 2;
        e_wr  = exec_wr_req && m_owner != 3;
        if (e_ifu && m_wait >= LIMIT) g = 1;
        else if (e_wr)                g = 3;
        else if (e_rd)                g = 2;
        else if (e_ifu)               g = 1;
        else                          g = 0;
        ea = (g == 1) ? ifu_rd_addr : (g == 2) ? exec_rd_addr : (g == 3) ? exec_wr_addr : '0;
        s_g = g; s_mem_req = mem_req; s_mem_we = mem_we; s_mem_addr = mem_addr;
        s_mem_wdata = mem_wdata; s_ifu_valid = ifu_rd_valid; s_ifu_data = ifu_rd_data;
        s_rd_valid = exec_rd_valid; s_rd_data = exec_rd_data; s_wr_done = exec_wr_done;
        chk("mem_req", 32'(mem_req), 32'(g != 0));
        chk("mem_we", 32'(mem_we), 32'(g == 3));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_wdata", 32'(mem_wdata), (g == 3) ? 32'(exec_wr_data) : 32'd0);
        chk("ifu_rd_valid", 32'(ifu_rd_valid), 32'(m_owner == 1));
        chk("exec_rd_valid", 32'(exec_rd_valid), 32'(m_owner == 2));
        chk("exec_wr_done", 32'(exec_wr_done), 32'(m_owner == 3));
        if (m_owner == 1) chk("ifu_rd_data", 32'(ifu_rd_data), 32'(m_rd_val));
        if (m_owner == 2) chk("exec_rd_data", 32'(exec_rd_data), 32'(m_rd_val));
        last_pulse = m_owner;
        @(posedge clk);
        if (g == 3) mem_arr[exec_wr_addr] = exec_wr_data;
        if (g == 1 || g == 2) m_rd_val = mem_arr[ea];
        if (g == 1) m_wait = 0;
        else if (e_ifu && m_wait < LIMIT) m_wait++;
        m_owner = g;
        #1;
        mem_rdata = (g == 1 || g == 2) ? m_rd_val : DW'($urandom);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_pulses"}, {29'd0, ifu_rd_valid, exec_rd_valid, exec_wr_done}, 32'd0);
    endtask

    task automatic rand_clients();
        if (!ifu_rd_req) begin
            if ($urandom_range(0, 2) == 0) begin ifu_rd_req = 1'b1; ifu_rd_addr = AW'($urandom_range(0, 15)); end
        end else if (last_pulse == 1) begin
            if ($urandom_range(0, 1) == 0) ifu_rd_req = 1'b0;
            else ifu_rd_addr = AW'($urandom_range(0, 15));
        end
        if (!exec_rd_req) begin
            if ($urandom_range(0, 2) == 0) begin exec_rd_req = 1'b1; exec_rd_addr = AW'($urandom_range(0, 15)); end
        end else if (last_pulse == 2) begin
            if ($urandom_range(0, 1) == 0) exec_rd_req = 1'b0;
            else exec_rd_addr = AW'($urandom_range(0, 15));
        end
        if (!exec_wr_req) begin
            if ($urandom_range(0, 2) == 0) begin
                exec_wr_req = 1'b1; exec_wr_addr = AW'($urandom_range(0, 15)); exec_wr_data = DW'($urandom);
            end
        end else if (last_pulse == 3) begin
            if ($urandom_range(0, 1) == 0) exec_wr_req = 1'b0;
            else begin exec_wr_addr = AW'($urandom_range(0, 15)); exec_wr_data = DW'($urandom); end
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = DW'(i) ^ 12'o5252;
        m_owner = 0; m_wait = 0; m_rd_val = '0; last_pulse = 0;
        reset_n = 1'b0;
        ifu_rd_req = 0; exec_rd_req = 0; exec_wr_req = 0;
        ifu_rd_addr = '0; exec_rd_addr = '0; exec_wr_addr = '0; exec_wr_data = '0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1 reset_n = 1'b1;

        // Lone fetch
        mem_arr[12'o0200] = 12'o7300;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;
        step();
        chk("lone_req", 32'(s_mem_req), 32'd1);
        chk("lone_we", 32'(s_mem_we), 32'd0);
        step();
        chk("lone_valid", 32'(s_ifu_valid), 32'd1);
        chk("lone_data", 32'(s_ifu_data), 32'o7300);
        ifu_rd_req = 1'b0;
        step();

        // Three-way collision
        ifu_rd_req = 1; ifu_rd_addr = 12'o0010;
        exec_rd_req = 1; exec_rd_addr = 12'o0020;
        exec_wr_req = 1; exec_wr_addr = 12'o0030; exec_wr_data = 12'o1234;
        step();
        chk("col_n_wr", {31'd0, s_mem_we}, 32'd1);
        chk("col_n_addr", 32'(s_mem_addr), 32'o0030);
        step();
        chk("col_n1_addr", 32'(s_mem_addr), 32'o0020);
        chk("col_n1_done", 32'(s_wr_done), 32'd1);
        exec_wr_req = 0;
        step();
        chk("col_n2_addr", 32'(s_mem_addr), 32'o0010);
        chk("col_n2_rdv", 32'(s_rd_valid), 32'd1);
        exec_rd_req = 0;
        step();
        chk("col_n3_ifv", 32'(s_ifu_valid), 32'd1);
        ifu_rd_req = 0;
        step();

        // Write then read
        exec_wr_req = 1; exec_wr_addr = 12'o0050; exec_wr_data = 12'o4321;
        step();
        exec_rd_req = 1; exec_rd_addr = 12'o0050;
        step();
        chk("wtr_done", 32'(s_wr_done), 32'd1);
        exec_wr_req = 0;
        step();
        chk("wtr_valid", 32'(s_rd_valid), 32'd1);
        chk("wtr_data", 32'(s_rd_data), 32'o4321);
        exec_rd_req = 0;
        repeat (2) step();

        // Starvation under alternating exec traffic
        ifu_rd_req = 1; ifu_rd_addr = 12'o0300;
        exec_rd_req = 1; exec_rd_addr = 12'o0301;
        exec_wr_req = 1; exec_wr_addr = 12'o0302; exec_wr_data = 12'o0777;
        n = 0;
        do begin step(); n++; end while (s_g != 1 && n < 20);
        chk("starve_first_wait", 32'(n), 32'd5);
        step();
        chk("starve_pulse", 32'(s_ifu_valid), 32'd1);
        n = 0;
        do begin step(); n++; end while (s_g != 1 && n < 20);
        chk("starve_second_wait", 32'(n), 32'd5);
        ifu_rd_req = 0; exec_rd_req = 0; exec_wr_req = 0;
        repeat (2) step();

        // Reset mid-flight
        ifu_rd_req = 1; ifu_rd_addr = 12'o0200;
        @(negedge clk);
        chk("rst_grant_req", 32'(mem_req), 32'd1);
        chk("rst_grant_addr", 32'(mem_addr), 32'o0200);
        reset_n = 1'b0;
        #1;
        chk_quiet("rst_low");
        m_owner = 0; m_wait = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("rst_held");
        @(posedge clk); #1 reset_n = 1'b1;
        step();
        chk("rst_regrant", 32'(s_g), 32'd1);
        chk("rst_regrant_req", 32'(s_mem_req), 32'd1);
        step();
        chk("rst_regrant_data", 32'(s_ifu_data), 32'o7300);
        ifu_rd_req = 0;
        step();

        // Idle
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_req", 32'(s_mem_req), 32'd0);
            chk("idle_pulses", {29'd0, s_ifu_valid, s_rd_valid, s_wr_done}, 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step();
            rand_clients();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
